io_uart_responder: RTL and testbench
====================================

Name: io_uart_responder

Overview:
IO-port responder on the far end of the processor's IO bus (IO_port_ID / IO_write_data / IO_write_strobe / IO_read_strobe / IO_read_data). It decodes three byte ports at BASE_PORT and feeds an 8N1 UART transmitter through a TX FIFO. An 8N1 UART receiver feeds an RX FIFO that the core reads back through the same ports. It sits beside processor_top and is clocked by the same clk100.

Parameters:
CLKS_PER_BIT, 868, clk100 cycles per UART bit (100 MHz / 115200).
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; must be a power of 2 and at least 2.
BASE_PORT, 8'h00, port ID of register 0; registers sit at BASE_PORT+0..+2.

Ports:
clk100  in  1  system clock
reset  in  1  asynchronous, active-high reset
IO_port_ID  in  8  port address from the EX stage
IO_write_data  in  8  write data; aligned with IO_write_strobe
IO_write_strobe  in  1  write qualifier; arrives one cycle after the matching IO_port_ID
IO_read_strobe  in  1  read qualifier; arrives one cycle after the matching IO_port_ID
IO_read_data  out  8  read data
uart_rxd  in  1  serial input; asynchronous to clk100
uart_txd  out  1  serial output; idles high

Behaviour:
- Clocking and reset: one clock, clk100. reset is asynchronous and active-high. All flops clear on reset.
- Values after reset:
  - uart_txd=1; both FIFOs empty; sticky flags 0.
  - RX synchronizer flops = 1; both FSMs in IDLE.
  - The status register therefore reads 8'h02.
- Port ID alignment: port_id_q is a register that captures IO_port_ID every cycle. Both strobes are decoded against port_id_q, not against the live IO_port_ID.
- Read data timing: IO_read_data is a combinational mux of the live IO_port_ID, so read data is valid in the same cycle the ID is presented.
- Register map:
  - BASE+0, TX data (write): push IO_write_data into the TX FIFO. Reads return 0.
  - BASE+1, status:
    - Read: bit0 tx_full, bit1 tx_empty, bit2 rx_valid (RX FIFO non-empty), bit3 rx_full, bit4 rx_overrun (sticky), bit5 tx_busy (FSM not IDLE), bit6 frame_err (sticky), bit7 = 0.
    - Write: a 1 in bit4 clears rx_overrun; a 1 in bit6 clears frame_err. Writing 0 has no effect.
  - BASE+2, RX data (read): returns the RX FIFO head, or 0 when empty. The FIFO pops on the edge where IO_read_strobe=1 and port_id_q==BASE+2. A pop when empty does nothing.
  - Any other port reads 8'h00. Writes to it are ignored.
- TX FIFO rules:
  - A push is accepted when count<FIFO_DEPTH, or when the FSM pops in the same cycle.
  - Otherwise the byte is silently dropped and no flag is set.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the FIFO is non-empty, pop the head into the shifter and go to START on the next edge.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles. At the end, go to START (popping the next byte) if the FIFO is non-empty, else to IDLE. There is no idle gap between back-to-back frames.
  - The bit counter is 3 bits; the baud counter is sized to $clog2(CLKS_PER_BIT).
- RX synchronizer: uart_rxd passes through a 2-flop synchronizer; rxs is the synchronized value.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on rxs (previous 1, current 0) goes to START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If rxs==1, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, CLKS_PER_BIT cycles apart, LSB first.
  - STOP: sample once, CLKS_PER_BIT after the last data bit, then return to IDLE.
    - Stop bit = 1 and FIFO not full: push the byte.
    - Stop bit = 1 and FIFO full: set rx_overrun and discard the byte.
    - Stop bit = 0: set frame_err and discard the byte.
- Simultaneous events:
  - RX push and core pop in the same cycle on a full FIFO: both happen, and no overrun is flagged.
  - A flag clear and a flag set in the same cycle: the set wins.
- Reset mid-frame: uart_txd returns to 1 immediately (asynchronous clear). Any partial RX frame is lost.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: the RX synchronizer input is uart_txd instead of uart_rxd, so every transmitted byte arrives in the RX FIFO. uart_rxd is ignored; uart_txd still drives the pin.
- Undefined: the RX synchronizer input is uart_rxd, and there is no loopback logic.

Test Plan (all scenarios use CLKS_PER_BIT=8, FIFO_DEPTH=4, BASE_PORT=8'h00):
1. Reset: assert reset mid-TX-frame, drive IO_port_ID=8'h01 -> uart_txd=1 asynchronously; IO_read_data=8'h02; status bit5=0.
2. Single TX: write 8'hA5 to port 0 -> START begins 2 cycles after the strobe. uart_txd shows 0,1,0,1,0,0,1,0,1,1 at 8 cycles each (START, 8'hA5 LSB first, STOP); tx_busy=1 during the frame; status returns to 8'h02 afterwards.
3. TX overflow: write 8'h01..8'h06 on 6 consecutive strobes -> 8'h01..8'h05 are transmitted back-to-back with no idle gap; 8'h06 is dropped; tx_full=1 after the 5th write.
4. RX receive: drive an 8'h3C frame on uart_rxd -> status bit2=1 after the stop sample; a read of port 2 returns 8'h3C; after the pop, status bit2=0.
5. RX overrun then clear: send 5 frames (8'h10..8'h14) without reads -> bit3=1 and bit4=1; reads of port 2 return 8'h10..8'h13. Write 8'h10 to port 1 -> bit4=0.
6. Framing error and glitch: send a frame with stop bit 0 -> no push, bit6=1. Send a 2-cycle low pulse -> no frame starts, and the RX FSM is back in IDLE within 5 cycles.

Source files
------------

// File: rtl/io_uart_responder.sv
// io_uart_responder
//   IO-port responder for the processor IO bus. Three byte ports at BASE_PORT:
//     +0  TX data   (write pushes into TX FIFO, read returns 0)
//     +1  status    (read: {0,frame_err,tx_busy,rx_overrun,rx_full,rx_valid,tx_empty,tx_full};
//                    write: 1 in bit4 clears rx_overrun, 1 in bit6 clears frame_err)
//     +2  RX data   (read returns RX FIFO head, strobe pops it)
//   An 8N1 transmitter drains the TX FIFO and an 8N1 receiver fills the RX FIFO.
// Ports:
//   clk100, reset (async, active high)
//   IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe -> bus inputs
//   IO_read_data -> combinational read data for the live IO_port_ID
//   uart_rxd (async serial in), uart_txd (serial out, idles high)
// Optional build macro: UART_LOOPBACK_EN feeds uart_txd back into the receiver.
module io_uart_responder #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] BASE_PORT    = 8'h00
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [7:0]    P_TX      = BASE_PORT;
  localparam logic [7:0]    P_ST      = BASE_PORT + 8'd1;
  localparam logic [7:0]    P_RX      = BASE_PORT + 8'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Strobes arrive one cycle after their port ID, so decode against the delayed ID.
  logic [7:0] port_id_q;
  always_ff @(posedge clk100 or posedge reset)
    if (reset) port_id_q <= '0;
    else       port_id_q <= IO_port_ID;

  logic wr_tx, wr_stat, rd_rx;
  assign wr_tx   = IO_write_strobe && (port_id_q == P_TX);
  assign wr_stat = IO_write_strobe && (port_id_q == P_ST);
  assign rd_rx   = IO_read_strobe  && (port_id_q == P_RX);

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_pop, tx_push, tx_empty, tx_full;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == DEPTH);
  assign tx_push  = wr_tx && (!tx_full || tx_pop);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q] <= IO_write_data;
        tx_wr_q           <= tx_wr_q + AW'(1);
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_state_q != S_IDLE && tx_baud_q != '0) tx_baud_d = tx_baud_q - BW'(1);
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_mem_q[tx_rd_q];
        tx_baud_d  = BAUD_LAST;
        tx_state_d = S_START;
      end
      S_START: if (tx_baud_q == '0) begin
        tx_baud_d  = BAUD_LAST;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_baud_q == '0) begin
        tx_baud_d  = BAUD_LAST;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end
      S_STOP: if (tx_baud_q == '0) begin
        // Back-to-back frames: chain straight into the next start bit.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_q];
          tx_baud_d  = BAUD_LAST;
          tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Output is registered from the next state so the pin never glitches.
    case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end
  assign uart_txd = txd_q;

  // ---------------- RX synchronizer ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = txd_q;
`else
  assign rx_src = uart_rxd;
`endif
  logic rx_s1_q, rxs_q, rx_prev_q;
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_src;
      rxs_q     <= rx_s1_q;
      rx_prev_q <= rxs_q;
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_e   rx_state_q, rx_state_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push_req, ferr_set;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    if (rx_state_q != S_IDLE && rx_baud_q != '0) rx_baud_d = rx_baud_q - BW'(1);
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rxs_q) begin
        rx_baud_d  = BAUD_HALF;
        rx_state_d = S_START;
      end
      S_START: if (rx_baud_q == '0) begin
        // Line back high at mid start bit: treat as a glitch.
        if (rxs_q) rx_state_d = S_IDLE;
        else begin
          rx_baud_d  = BAUD_LAST;
          rx_bit_d   = '0;
          rx_state_d = S_DATA;
        end
      end
      S_DATA: if (rx_baud_q == '0) begin
        rx_baud_d  = BAUD_LAST;
        rx_shift_d = {rxs_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_baud_q == '0) begin
        rx_state_d = S_IDLE;
        if (rxs_q) rx_push_req = 1'b1;
        else       ferr_set    = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q;
  logic [CW-1:0] rx_cnt_q;
  logic          rx_empty, rx_full, rx_pop, rx_push, ovr_set;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH);
  assign rx_pop   = rd_rx && !rx_empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign ovr_set  = rx_push_req && rx_full && !rx_pop;
  // Set wins over a same-cycle clear.
  assign ovr_d    = ovr_set  || (ovr_q  && !(wr_stat && IO_write_data[4]));
  assign ferr_d   = ferr_set || (ferr_q && !(wr_stat && IO_write_data[6]));

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= rx_shift_d;
        rx_wr_q           <= rx_wr_q + AW'(1);
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  // ---------------- Read mux (live port ID) ----------------
  logic [7:0] status;
  assign status = {1'b0, ferr_q, (tx_state_q != S_IDLE), ovr_q,
                   rx_full, !rx_empty, tx_empty, tx_full};

  always_comb begin
    IO_read_data = '0;
    if (IO_port_ID == P_ST)                    IO_read_data = status;
    else if (IO_port_ID == P_RX && !rx_empty)  IO_read_data = rx_mem_q[rx_rd_q];
  end
endmodule

// File: tb/tb_io_uart_responder.sv
// Testbench for io_uart_responder (CLKS_PER_BIT=8, FIFO_DEPTH=4, BASE_PORT=0).
// TX bytes are queued when written and checked by a serial decoder on uart_txd;
// RX bytes are queued when a valid frame is driven and checked on port 2 reads.
module tb_io_uart_responder;
  logic       clk100 = 1'b0;
  logic       reset;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic       uart_rxd;
  logic       uart_txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_start = 0;
  logic have_prev = 1'b0;
  logic chk_gap = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  io_uart_responder #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4), .BASE_PORT(8'h00)) dut (
    .clk100(clk100), .reset(reset), .IO_port_ID(IO_port_ID),
    .IO_write_data(IO_write_data), .IO_write_strobe(IO_write_strobe),
    .IO_read_strobe(IO_read_strobe), .IO_read_data(IO_read_data),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd));

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    @(posedge clk100); #1 IO_port_ID = p;
    @(posedge clk100); #1 IO_write_strobe = 1'b1; IO_write_data = d;
    @(posedge clk100); #1 IO_write_strobe = 1'b0;
  endtask

  task automatic peek(input logic [7:0] p, output logic [7:0] d);
    @(posedge clk100); #1 IO_port_ID = p;
    @(negedge clk100); d = IO_read_data;
  endtask

  task automatic pop_rx(output logic [7:0] d);
    peek(8'h02, d);
    @(posedge clk100); #1 IO_read_strobe = 1'b1;
    @(posedge clk100); #1 IO_read_strobe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk100); #1 uart_rxd = 1'b0;
    repeat (8) @(posedge clk100);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rxd = b[i];
      repeat (8) @(posedge clk100);
    end
    #1 uart_rxd = stop_bit;
    repeat (8) @(posedge clk100);
    #1 uart_rxd = 1'b1;
    repeat (2) @(posedge clk100);
  endtask

  task automatic rx_check_pop();
    logic [7:0] d;
    pop_rx(d);
    chk("rx_q_nonempty", rx_exp.size() != 0, 1);
    if (rx_exp.size() != 0) chk("rx_data", d, rx_exp.pop_front());
  endtask

  task automatic tx_monitor();
    logic [7:0] b;
    forever begin
      @(negedge clk100);
      if (uart_txd === 1'b0) begin
        if (chk_gap && have_prev) chk("tx_gap", cyc - prev_start, 80);
        prev_start = cyc;
        have_prev  = 1'b1;
        repeat (4) @(negedge clk100);
        chk("tx_start_mid", uart_txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk100);
          b[i] = uart_txd;
        end
        repeat (8) @(negedge clk100);
        chk("tx_stop", uart_txd, 1);
        chk("tx_q_nonempty", tx_exp.size() != 0, 1);
        if (tx_exp.size() != 0) chk("tx_byte", b, tx_exp.pop_front());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [9:0] bits;
    reset = 1'b1; IO_port_ID = 8'h01; IO_write_data = '0;
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0; uart_rxd = 1'b1;
    repeat (3) @(posedge clk100);
    #1 reset = 1'b0;

    // 1. reset state, then reset in the middle of a TX frame
    peek(8'h01, d);
    chk("rst_status", d, 8'h02);
    wr(8'h00, 8'h00);
    repeat (30) @(negedge clk100);
    chk("pre_rst_txd", uart_txd, 0);
    IO_port_ID = 8'h01;
    #2 reset = 1'b1;
    #1 chk("rst_txd_async", uart_txd, 1);
    chk("rst_status_mid", IO_read_data, 8'h02);
    chk("rst_busy", IO_read_data[5], 0);
    repeat (3) @(posedge clk100);
    #1 reset = 1'b0;
    fork tx_monitor(); join_none

    // 2. single TX byte, bit-level timing
    tx_exp.push_back(8'hA5);
    wr(8'h00, 8'hA5);
    IO_port_ID = 8'h01;
    @(negedge clk100); chk("tx_lat_idle", uart_txd, 1);
    @(negedge clk100); chk("tx_lat_start", uart_txd, 0);
    bits = {1'b1, 8'hA5, 1'b0};
    repeat (3) @(negedge clk100);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), uart_txd, bits[i]);
      if (i == 4) chk("tx_busy", IO_read_data[5], 1);
      repeat (8) @(negedge clk100);
    end
    chk("tx_done_status", IO_read_data, 8'h02);

    // 3. TX overflow burst: six writes, fifth fills, sixth dropped
    chk_gap = 1'b1; have_prev = 1'b0;
    @(posedge clk100); #1 IO_port_ID = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk100); #1 IO_write_strobe = 1'b1; IO_write_data = 8'(i);
      if (i <= 5) tx_exp.push_back(8'(i));
    end
    @(posedge clk100); #1 IO_write_strobe = 1'b0;
    peek(8'h01, d);
    chk("tx_full", d[0], 1);
    for (int k = 0; k < 2000 && tx_exp.size() != 0; k++) @(negedge clk100);
    chk("tx_drain", tx_exp.size(), 0);
    repeat (100) @(negedge clk100);
    chk_gap = 1'b0;
    peek(8'h01, d);
    chk("tx_burst_status", d, 8'h02);

    // 4. single RX byte
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    peek(8'h01, d);
    chk("rx_valid", d, 8'h06);
    rx_check_pop();
    peek(8'h01, d);
    chk("rx_after_pop", d, 8'h02);

    // 5. overrun: five frames, four kept
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1);
    end
    peek(8'h01, d);
    chk("rx_ovr_status", d, 8'h1E);
    for (int i = 0; i < 4; i++) rx_check_pop();
    peek(8'h01, d);
    chk("rx_ovr_sticky", d, 8'h12);
    wr(8'h01, 8'h10);
    peek(8'h01, d);
    chk("rx_ovr_clear", d, 8'h02);

    // 6. framing error, then glitch, then a clean frame
    send_frame(8'hA5, 1'b0);
    peek(8'h01, d);
    chk("rx_ferr", d, 8'h42);
    wr(8'h01, 8'h40);
    peek(8'h01, d);
    chk("rx_ferr_clear", d, 8'h02);
    @(posedge clk100); #1 uart_rxd = 1'b0;
    repeat (2) @(posedge clk100);
    #1 uart_rxd = 1'b1;
    repeat (10) @(posedge clk100);
    peek(8'h01, d);
    chk("rx_glitch", d, 8'h02);
    rx_exp.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    rx_check_pop();
    peek(8'h01, d);
    chk("rx_final_status", d, 8'h02);
    chk("rx_q_drained", rx_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
